adc_acq_sequencer: RTL and testbench
====================================

Name: adc_acq_sequencer

Overview:
- Sequences acquisition runs on the ADC trigger block by programming it as an AXI4-Lite master.
- Holds a table of up to DEPTH entries, each with a divider, an averages value and a block count.
- Each entry: write the divider and averages registers, then arm one-shot runs by writing the config start bit, once per DMA block, counting `last` pulses.
- Sits between the PS-side control logic and the trigger's AXI4-Lite subordinate port.

Parameters:
- DEPTH, 8, number of table entries (power of 2, ≥2).
- TRIG_BASE, 32'h4000_0000, base address of the trigger subordinate.
- TIMEOUT_CYCLES, 50_000_000, watchdog limit in aclk cycles (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_idx  in  $clog2(DEPTH)  entry index.
- tbl_wr_data  in  64  entry fields: [31:0] divider, [47:32] averages, [63:48] blocks.
- num_entries  in  $clog2(DEPTH)+1  active entries; sampled at start.
- loop_en  in  1  restart at entry 0 after the last entry; sampled at start.
- start  in  1  pulse: begin sequence.
- abort  in  1  pulse: stop sequence.
- last  in  1  one-cycle pulse marking DMA transaction complete.
- busy  out  1  sequence active.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky error flag.
- cur_idx  out  $clog2(DEPTH)  entry currently executing.
- blocks_done  out  16  blocks completed in the current entry.
- m_axi_awaddr  out  32;  m_axi_awprot  out  3 (tied 0);  m_axi_awvalid  out  1;  m_axi_awready  in  1.
- m_axi_wdata  out  32;  m_axi_wstrb  out  4 (tied 4'hF);  m_axi_wvalid  out  1;  m_axi_wready  in  1.
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1.

Behaviour:
- Reset and clock: aresetn is asynchronous, active-low; aclk is the clock. On reset, all outputs are 0, the FSM is in IDLE, and the table contents are undefined.
- Register targets: TRIG_BASE+0x104 divider, +0x108 averages, +0x100 config. The config write data is always 32'h2 (bit1 = start, bit0 = 0, one-shot).
- FSM states: IDLE, LOAD, WR_DIV, WR_AVG, WR_CFG, RUN, NEXT, DRAIN.
- IDLE:
  - start with num_entries==0 → done pulse next cycle; stay in IDLE.
  - start otherwise → clear error, idx=0, busy=1, go to LOAD.
  - start while busy is ignored.
- LOAD: latch table[idx], clear blocks_done.
  - blocks==0 → go to NEXT (entry skipped, no writes issued).
  - otherwise → go to WR_DIV.
- AXI write (WR_* states):
  - awvalid and wvalid are raised together on state entry. Each drops independently on its own handshake.
  - bready rises once both handshakes are done.
  - On bvalid&bready: bresp != 0 → error=1, go to IDLE; otherwise advance WR_DIV→WR_AVG→WR_CFG→RUN.
  - Minimum 3 cycles per write with a zero-wait subordinate.
- RUN, on last:
  - blocks_done += 1.
  - If the new value < blocks, go to WR_CFG (re-arm).
  - Otherwise go to NEXT.
  - last outside RUN is ignored.
- NEXT: idx += 1.
  - idx == num_entries and loop_en → idx=0, go to LOAD.
  - idx == num_entries and !loop_en → done pulse, busy=0, go to IDLE.
  - Otherwise → go to LOAD.
- abort:
  - In RUN, LOAD or NEXT → IDLE next cycle.
  - In WR_* → DRAIN: outstanding valids and bready are held until every handshake and the response complete, then go to IDLE.
  - No done pulse; error unchanged.
  - Abort is not re-sampled in DRAIN.
- Simultaneous events:
  - start and abort together in IDLE: abort wins, sequence not started.
  - last and abort together in RUN: abort wins, blocks_done still increments.
- tbl_wr_en while busy is ignored. Table writes while idle take effect immediately.
- cur_idx mirrors idx; blocks_done resets to 0 on each LOAD.
- All counters are unsigned; blocks_done compares against the full 16 bits.

Optional Feature:
ACQ_SEQ_TIMEOUT_EN:
- Defined: a 32-bit watchdog clears on RUN entry and on each last. If it reaches TIMEOUT_CYCLES in RUN → error=1, busy=0, go to IDLE, no done pulse.
- Undefined: RUN waits for last indefinitely and no watchdog logic exists.

Decomposition:
- Package adc_acq_pkg:
  - FSM state encoding.
  - Register offsets CFG=0x100, DIV=0x104, AVG=0x108.
  - CFG_START_WORD=32'h2.
  - Entry field bit ranges.
- Sub-module axil_single_writer:
  - Ports: req, addr, data, drain; ack, err.
  - Owns the AW/W/B handshake for exactly one write.
  - Reusable for other register-programming masters.

Test Plan:
- Two entries ({div=10, avg=1, blocks=1}, {div=20, avg=4, blocks=2}), num_entries=2, zero-wait subordinate, last pulses issued → write order DIV 10, AVG 1, CFG 2, DIV 20, AVG 4, CFG 2, CFG 2; exactly one done pulse; busy falls the cycle after done.
- Subordinate delays awready 3 cycles and wready 5 cycles, and returns bvalid 2 cycles later → each valid drops only on its own handshake; no duplicate writes; bready high only after both.
- bresp=2'b10 on the AVG write → error=1 and busy=0; no CFG write issued; the next start clears error.
- Abort asserted while awvalid is pending → transaction completes (DRAIN), then IDLE; no done; no further writes.
- loop_en=1, one entry with blocks=1 → after the first last, DIV/AVG/CFG are rewritten for entry 0; abort in RUN returns to IDLE within 1 cycle. Second run: entry with blocks=0 → skipped, done with zero AXI writes.
- With ACQ_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100 → no last for 100 cycles in RUN → error=1, busy=0; a last at cycle 99 restarts the watchdog.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer: FSM encoding,
// trigger register offsets and table-entry field positions.
package adc_acq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WR_DIV = 3'd2;
  localparam logic [2:0] S_WR_AVG = 3'd3;
  localparam logic [2:0] S_WR_CFG = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_DRAIN  = 3'd7;

  localparam logic [31:0] OFF_CFG = 32'h100;
  localparam logic [31:0] OFF_DIV = 32'h104;
  localparam logic [31:0] OFF_AVG = 32'h108;

  // bit1 = start, bit0 = 0 selects one-shot mode
  localparam logic [31:0] CFG_START_WORD = 32'h2;

  localparam int ENT_DIV_LSB = 0;
  localparam int ENT_DIV_MSB = 31;
  localparam int ENT_AVG_LSB = 32;
  localparam int ENT_AVG_MSB = 47;
  localparam int ENT_BLK_LSB = 48;
  localparam int ENT_BLK_MSB = 63;

  function automatic logic is_wr_state(input logic [2:0] s);
    return (s == S_WR_DIV) || (s == S_WR_AVG) || (s == S_WR_CFG);
  endfunction

endpackage

// File: rtl/axil_single_writer.sv
// Single AXI4-Lite write master: launches one AW/W pair on req, drops each
// valid on its own handshake, raises bready once both have completed and
// reports ack (and err on a non-OKAY response) when the response is taken.
// While drain is high no new write is launched; an outstanding one finishes.
module axil_single_writer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        drain,
  output logic        ack,
  output logic        err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  logic        awv_q, awv_d, wv_q, wv_d, bready_q, bready_d, pend_q, pend_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;

  assign ack = bready_q && m_axi_bvalid;
  assign err = ack && (m_axi_bresp != 2'b00);

  // Handshake bookkeeping; a new request may overlap the response cycle.
  always_comb begin
    awv_d    = awv_q;
    wv_d     = wv_q;
    bready_d = bready_q;
    pend_d   = pend_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (awv_q && m_axi_awready) awv_d = 1'b0;
    if (wv_q && m_axi_wready)   wv_d  = 1'b0;
    if (pend_q && !awv_q && !wv_q) bready_d = 1'b1;
    if (ack) begin
      bready_d = 1'b0;
      pend_d   = 1'b0;
    end
    if (req && !drain && (!pend_q || ack)) begin
      awv_d  = 1'b1;
      wv_d   = 1'b1;
      pend_d = 1'b1;
      addr_d = addr;
      data_d = data;
    end
  end

  // Channel state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      bready_q <= 1'b0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      bready_q <= bready_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wvalid  = wv_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: walks a table of {divider, averages, blocks}
// entries and programs the trigger block over AXI4-Lite, re-arming a one-shot
// run once per DMA block and counting last pulses.
// Optional macro ACQ_SEQ_TIMEOUT_EN adds a RUN-state watchdog.
module adc_acq_sequencer
  import adc_acq_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] TRIG_BASE = 32'h4000_0000
`ifdef ACQ_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0] tbl_wr_idx,
  input  logic [63:0]              tbl_wr_data,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     last,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic [15:0]              blocks_done,
  output logic [31:0]              m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready
);

  localparam int IW = $clog2(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   num_q, num_d, idx_inc;
  logic          loop_q, loop_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [63:0]   ent_q, ent_d;
  logic [15:0]   bd_q, bd_d;
  logic [63:0]   tbl_q [DEPTH];
  logic          wr_req, wr_ack, wr_err;
  logic [31:0]   wr_addr, wr_data;
`ifdef ACQ_SEQ_TIMEOUT_EN
  logic [31:0]   wd_q, wd_d;
`endif

  assign idx_inc = {1'b0, idx_q} + (IW+1)'(1);

  // Entry table: writable only while no sequence is active
  always_ff @(posedge aclk) begin
    if (tbl_wr_en && !busy_q) tbl_q[tbl_wr_idx] <= tbl_wr_data;
  end

  // Sequencer next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    loop_d  = loop_q;
    ent_d   = ent_q;
    bd_d    = bd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef ACQ_SEQ_TIMEOUT_EN
    wd_d = (state_q == S_RUN && !last) ? wd_q + 32'd1 : 32'd0;
`endif
    case (state_q)
      S_IDLE: begin
        // busy lingers for the done cycle so it falls one cycle after done
        if (busy_q) busy_d = 1'b0;
        else if (start && !abort) begin
          if (num_entries == '0) done_d = 1'b1;
          else begin
            err_d   = 1'b0;
            idx_d   = '0;
            busy_d  = 1'b1;
            num_d   = num_entries;
            loop_d  = loop_en;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ent_d   = tbl_q[idx_q];
          bd_d    = '0;
          state_d = (ent_d[ENT_BLK_MSB:ENT_BLK_LSB] == 16'd0) ? S_NEXT : S_WR_DIV;
        end
      end
      S_WR_DIV, S_WR_AVG, S_WR_CFG: begin
        if (wr_ack) begin
          if (wr_err || abort) begin
            err_d   = err_q | wr_err;
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (state_q == S_WR_DIV) state_d = S_WR_AVG;
          else if (state_q == S_WR_AVG)     state_d = S_WR_CFG;
          else                              state_d = S_RUN;
        end else if (abort) state_d = S_DRAIN;
      end
      S_RUN: begin
        if (last) bd_d = bd_q + 16'd1;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (last) begin
          state_d = (bd_d < ent_q[ENT_BLK_MSB:ENT_BLK_LSB]) ? S_WR_CFG : S_NEXT;
        end
`ifdef ACQ_SEQ_TIMEOUT_EN
        else if (wd_d >= 32'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`endif
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_inc[IW-1:0];
          state_d = S_LOAD;
          if (idx_inc == num_q) begin
            if (loop_q) idx_d = '0;
            else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        if (wr_ack) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A write is launched on every entry into a WR_* state
  always_comb begin
    wr_req  = is_wr_state(state_d) && (state_d != state_q);
    wr_addr = TRIG_BASE + OFF_CFG;
    wr_data = CFG_START_WORD;
    if (state_d == S_WR_DIV) begin
      wr_addr = TRIG_BASE + OFF_DIV;
      wr_data = ent_d[ENT_DIV_MSB:ENT_DIV_LSB];
    end else if (state_d == S_WR_AVG) begin
      wr_addr = TRIG_BASE + OFF_AVG;
      wr_data = {16'd0, ent_d[ENT_AVG_MSB:ENT_AVG_LSB]};
    end
  end

  // Sequencer state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      loop_q  <= 1'b0;
      ent_q   <= '0;
      bd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      loop_q  <= loop_d;
      ent_q   <= ent_d;
      bd_q    <= bd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef ACQ_SEQ_TIMEOUT_EN
  // Watchdog counter, cleared outside RUN and on each last
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  axil_single_writer u_wr (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req           (wr_req),
    .addr          (wr_addr),
    .data          (wr_data),
    .drain         (state_q == S_DRAIN),
    .ack           (wr_ack),
    .err           (wr_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign cur_idx      = idx_q;
  assign blocks_done  = bd_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Bench for adc_acq_sequencer: AXI4-Lite subordinate with programmable
// delays, write log, and a table-level model of the expected write stream.
module tb_adc_acq_sequencer;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_CFG = 32'h4000_0100;
  localparam logic [31:0] A_DIV = 32'h4000_0104;
  localparam logic [31:0] A_AVG = 32'h4000_0108;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic tbl_wr_en = 1'b0, loop_en = 1'b0, start = 1'b0, abort = 1'b0, last = 1'b0;
  logic [2:0]  tbl_wr_idx = '0;
  logic [63:0] tbl_wr_data = '0;
  logic [3:0]  num_entries = '0;
  logic        busy, done, error;
  logic [2:0]  cur_idx;
  logic [15:0] blocks_done;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;

  always #5 aclk = ~aclk;

  adc_acq_sequencer #(.DEPTH(DEPTH), .TRIG_BASE(32'h4000_0000)) dut (
    .aclk(aclk), .aresetn(aresetn), .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_data(tbl_wr_data), .num_entries(num_entries), .loop_en(loop_en),
    .start(start), .abort(abort), .last(last), .busy(busy), .done(done),
    .error(error), .cur_idx(cur_idx), .blocks_done(blocks_done),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main sequence drives at +2 so the subordinate (+1) has already updated.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge aclk); #2; end
  endtask

  // ---------------- subordinate model and write log ----------------
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         log_q[$];
  int          bcount = 0, done_cnt = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  bit          fail_en = 0;
  logic [31:0] fail_addr = '0;

  initial begin : sub
    bit aw_hs, w_hs, b_hs, got_aw, got_w, b_pend, p_awv, p_wv, p_aw_hs, p_w_hs;
    logic [31:0] sa, sd, cur_a, cur_d;
    int aw_wait, w_wait, b_wait;
    {got_aw, got_w, b_pend, p_awv, p_wv, p_aw_hs, p_w_hs} = '0;
    aw_wait = 0; w_wait = 0; b_wait = 0; cur_a = '0; cur_d = '0;
    forever begin
      @(negedge aclk);
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      sa = m_axi_awaddr; sd = m_axi_wdata;
      if (aresetn) begin
        if (p_awv && !p_aw_hs) check("awvalid_hold", m_axi_awvalid, 1);
        if (p_wv && !p_w_hs)   check("wvalid_hold", m_axi_wvalid, 1);
        if (m_axi_bready)      check("bready_after_aw_w", {got_aw, got_w}, 2'b11);
      end
      p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_aw_hs = aw_hs; p_w_hs = w_hs;
      @(posedge aclk); #1;
      if (aw_hs) begin got_aw = 1; cur_a = sa; end
      if (w_hs)  begin got_w = 1;  cur_d = sd; end
      if (b_hs) begin
        m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        got_aw = 0; got_w = 0; b_pend = 0; bcount++;
      end else if (got_aw && got_w && !b_pend) begin
        log_q.push_back({cur_a, cur_d});
        b_pend = 1; b_wait = b_dly;
      end
      if (b_pend && !m_axi_bvalid) begin
        if (b_wait == 0) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (fail_en && cur_a == fail_addr) ? 2'b10 : 2'b00;
        end else b_wait--;
      end
      m_axi_awready = m_axi_awvalid && !got_aw && (aw_wait >= aw_dly);
      aw_wait = (m_axi_awvalid && !got_aw) ? aw_wait + 1 : 0;
      m_axi_wready = m_axi_wvalid && !got_w && (w_wait >= w_dly);
      w_wait = (m_axi_wvalid && !got_w) ? w_wait + 1 : 0;
    end
  end

  initial forever begin
    @(negedge aclk);
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- table-level reference model ----------------
  logic [31:0] m_div[DEPTH];
  logic [15:0] m_avg[DEPTH], m_blk[DEPTH];
  typedef struct { logic [31:0] a; logic [31:0] d; int ent; int k; } exp_t;
  exp_t exp_q[$];

  task automatic tbl_write(input int i, input logic [31:0] dv, input logic [15:0] av,
                           input logic [15:0] bk);
    tbl_wr_en = 1; tbl_wr_idx = 3'(i); tbl_wr_data = {bk, av, dv};
    tick();
    tbl_wr_en = 0;
    m_div[i] = dv; m_avg[i] = av; m_blk[i] = bk;
  endtask

  // Each non-empty entry: DIV, AVG, then one CFG start per block.
  task automatic build(input int num);
    exp_q.delete();
    for (int e = 0; e < num; e++) begin
      if (m_blk[e] != 0) begin
        exp_q.push_back('{A_DIV, m_div[e], e, 0});
        exp_q.push_back('{A_AVG, {16'd0, m_avg[e]}, e, 0});
        for (int k = 0; k < int'(m_blk[e]); k++) exp_q.push_back('{A_CFG, 32'h2, e, k});
      end
    end
  endtask

  task automatic wait_b(input int n, input string tag);
    int b = 0;
    while (bcount < n && b < 400) begin tick(); b++; end
    check(tag, bcount, n);
  endtask

  task automatic cmp_log(input int from, input int n, input string tag);
    for (int i = 0; i < n && (from + i) < log_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {log_q[from+i].a, log_q[from+i].d},
            {exp_q[i].a, exp_q[i].d});
  endtask

  task automatic run_normal(input int num, input bit poke);
    int d0, b;
    build(num);
    log_q.delete(); bcount = 0; d0 = done_cnt;
    num_entries = 4'(num); loop_en = 0;
    start = 1; tick(); start = 0;
    check("start_busy", busy, 1);
    check("start_err_clr", error, 0);
    if (poke && num >= 2) begin
      tbl_wr_en = 1; tbl_wr_idx = 3'(num - 1); tbl_wr_data = {$urandom, $urandom};
      tick(); tbl_wr_en = 0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].a == A_CFG) begin
        wait_b(i + 1, "cfg_resp_wait");
        tick($urandom_range(0, 3));
        check("run_cur_idx", cur_idx, exp_q[i].ent);
        check("run_blocks_done", blocks_done, exp_q[i].k);
        last = 1; tick(); last = 0;
      end
    end
    b = 0;
    while (done !== 1'b1 && b < 400) begin tick(); b++; end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 1);
    check("blocks_done_final", blocks_done, m_blk[num-1]);
    tick();
    check("busy_after_done", busy, 0);
    check("done_width", done, 0);
    check("done_count", done_cnt - d0, 1);
    check("run_error", error, 0);
    check("wr_count", log_q.size(), exp_q.size());
    cmp_log(0, exp_q.size(), "run");
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int d0, b;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cur_idx", cur_idx, 0);
    check("rst_blocks_done", blocks_done, 0);
    check("rst_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awprot}, 0);
    aresetn = 1; tick(2);

    // two-entry sequence, zero-wait subordinate
    tbl_write(0, 32'd10, 16'd1, 16'd1);
    tbl_write(1, 32'd20, 16'd4, 16'd2);
    run_normal(2, 0);

    // slow subordinate
    aw_dly = 3; w_dly = 5; b_dly = 2;
    run_normal(2, 0);
    aw_dly = 0; w_dly = 0; b_dly = 0;

    // error response on AVG write
    fail_en = 1; fail_addr = A_AVG;
    build(2); log_q.delete(); bcount = 0; d0 = done_cnt;
    num_entries = 4'd2; start = 1; tick(); start = 0;
    wait_b(2, "err_resp_wait");
    check("err_flag", error, 1);
    check("err_busy", busy, 0);
    tick(10);
    check("err_no_cfg", log_q.size(), 2);
    cmp_log(0, 2, "err");
    check("err_no_done", done_cnt - d0, 0);
    fail_en = 0;
    run_normal(2, 0);

    // abort while awvalid is pending -> drain
    aw_dly = 6;
    log_q.delete(); bcount = 0; d0 = done_cnt;
    start = 1; tick(); start = 0;
    b = 0;
    while (m_axi_awvalid !== 1'b1 && b < 50) begin tick(); b++; end
    check("drain_aw_pending", m_axi_awvalid, 1);
    tick();
    abort = 1; tick(); abort = 0;
    check("drain_busy", busy, 1);
    check("drain_aw_held", m_axi_awvalid, 1);
    b = 0;
    while (busy !== 1'b0 && b < 50) begin tick(); b++; end
    check("drain_idle", busy, 0);
    check("drain_resp", bcount, 1);
    tick(20);
    check("drain_one_write", log_q.size(), 1);
    if (log_q.size() > 0) check("drain_wr", {log_q[0].a, log_q[0].d}, {A_DIV, 32'd10});
    check("drain_no_done", done_cnt - d0, 0);
    check("drain_error", error, 0);
    aw_dly = 0;

    // loop mode, one entry; last+abort together in RUN
    tbl_write(0, $urandom, 16'($urandom), 16'd1);
    build(1); log_q.delete(); bcount = 0; d0 = done_cnt;
    num_entries = 4'd1; loop_en = 1;
    start = 1; tick(); start = 0;
    wait_b(3, "loop_first");
    tick($urandom_range(0, 3));
    last = 1; tick(); last = 0;
    wait_b(6, "loop_second");
    check("loop_wr_count", log_q.size(), 6);
    cmp_log(0, 3, "loop_a");
    cmp_log(3, 3, "loop_b");
    check("loop_bd_clear", blocks_done, 0);
    last = 1; abort = 1; tick(); last = 0; abort = 0;
    check("abort_run_busy", busy, 0);
    check("abort_run_bd", blocks_done, 1);
    tick(10);
    check("abort_run_no_wr", log_q.size(), 6);
    check("abort_run_no_done", done_cnt - d0, 0);
    loop_en = 0;

    // skipped entry (blocks=0): done with no writes
    tbl_write(0, 32'd7, 16'd7, 16'd0);
    run_normal(1, 0);

    // num_entries==0: immediate done, never busy
    d0 = done_cnt; num_entries = 4'd0;
    start = 1; tick(); start = 0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_count", done_cnt - d0, 1);

    // start and abort together in IDLE
    tbl_write(0, 32'd5, 16'd5, 16'd1);
    log_q.delete(); num_entries = 4'd1;
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("start_abort_busy", busy, 0);
    tick(5);
    check("start_abort_no_wr", log_q.size(), 0);

    // randomized tables, sizes and subordinate timing
    repeat (6) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      for (int e = 0; e < DEPTH; e++)
        tbl_write(e, $urandom, 16'($urandom), 16'($urandom_range(0, 3)));
      run_normal($urandom_range(1, DEPTH), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
